// File: rtl/vpu_reduction_seq.sv
// Reduction sequencer: accepts one FSUM/FMAX vector request, streams it to the datapath
// as EXEC_CNT back-to-back beats, then waits (with timeout) and returns the scalar result.
module vpu_reduction_seq #(
  parameter int OPERAND_WIDTH   = 16,
  parameter int DWIDTH_PER_EXEC = 256,
  parameter int EXEC_CNT        = 2,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic                                req_is_sum_i,
  input  logic [EXEC_CNT*DWIDTH_PER_EXEC-1:0] req_data_i,
  output logic                                red_start_o,
  output logic                                red_is_sum_o,
  output logic [DWIDTH_PER_EXEC-1:0]          red_operand_o,
  input  logic [DWIDTH_PER_EXEC-1:0]          red_dout_i,
  input  logic                                red_done_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]            rsp_data_o,
  output logic                                rsp_err_o,
  output logic                                spurious_o,
  output logic [15:0]                         op_cnt_o
);

  localparam int BW = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(EXEC_CNT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]                 state_q;
  logic [BW-1:0]              beat_cnt_q;
  logic [TW-1:0]              to_cnt_q;
  logic                       is_sum_q;
  logic [OPERAND_WIDTH-1:0]   rsp_data_q;
  logic                       rsp_err_q;
  logic                       spurious_q;
  logic [15:0]                op_cnt_q;
  logic [DWIDTH_PER_EXEC-1:0] beat_q [EXEC_CNT];
  logic                       unused_dout;

  // Only lane 0 of the broadcast result is consumed.
  assign unused_dout = ^red_dout_i[DWIDTH_PER_EXEC-1:OPERAND_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      to_cnt_q   <= '0;
      is_sum_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      spurious_q <= 1'b0;
      op_cnt_q   <= '0;
    end else begin
      if (red_done_i && (state_q != WAIT)) spurious_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            is_sum_q   <= req_is_sum_i;
            beat_cnt_q <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            state_q    <= WAIT;
          end else begin
            beat_cnt_q <= beat_cnt_q + BW'(1);
          end
        end
        WAIT: begin
          // A done landing on the timeout cycle still delivers valid data.
          if (red_done_i) begin
            rsp_data_q <= red_dout_i[OPERAND_WIDTH-1:0];
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else if (to_cnt_q == TO_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            op_cnt_q <= op_cnt_q + 16'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid_i) begin
      for (int k = 0; k < EXEC_CNT; k++) begin
        beat_q[k] <= req_data_i[k*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC];
      end
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign red_start_o   = (state_q == ISSUE);
  assign red_operand_o = red_start_o ? beat_q[beat_cnt_q] : '0;
  assign red_is_sum_o  = is_sum_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign spurious_o    = spurious_q;
  assign op_cnt_o      = op_cnt_q;

endmodule

// File: tb/tb_vpu_reduction_seq.sv
// Directed bench for vpu_reduction_seq with a small datapath model driving done/dout.
module tb_vpu_reduction_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_is_sum_i;
  logic [511:0] req_data_i;
  logic         red_start_o;
  logic         red_is_sum_o;
  logic [255:0] red_operand_o;
  logic [255:0] red_dout_i;
  logic         red_done_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [15:0]  rsp_data_o;
  logic         rsp_err_o;
  logic         spurious_o;
  logic [15:0]  op_cnt_o;

  int total = 0;
  int bad   = 0;

  // datapath model controls
  logic model_en   = 1'b0;
  int   model_dly  = 1;
  logic spur_pulse = 1'b0;
  int   dcnt       = 0;
  logic bi         = 1'b0;

  vpu_reduction_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_sum_i(req_is_sum_i), .req_data_i(req_data_i),
    .red_start_o(red_start_o), .red_is_sum_o(red_is_sum_o),
    .red_operand_o(red_operand_o), .red_dout_i(red_dout_i),
    .red_done_i(red_done_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .spurious_o(spurious_o), .op_cnt_o(op_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Done fires model_dly cycles after the second beat is seen.
  initial begin
    red_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      red_done_i = 1'b0;
      if (spur_pulse) begin
        red_done_i = 1'b1;
        spur_pulse = 1'b0;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) red_done_i = 1'b1;
      end
      if (model_en && red_start_o) begin
        if (bi) begin
          dcnt = model_dly;
          bi   = 1'b0;
        end else begin
          bi = 1'b1;
        end
      end
    end
  end

  // Drives one accepted request and checks both beats; returns in the first WAIT cycle.
  task automatic issue(input logic is_sum, input logic [511:0] vec);
    chk("idle_ready", req_ready_o, 1);
    req_valid_i  = 1'b1;
    req_is_sum_i = is_sum;
    req_data_i   = vec;
    tick();
    req_valid_i = 1'b0;
    req_data_i  = '0;
    chk("beat0_start", red_start_o, 1);
    chk("beat0_data", red_operand_o, vec[255:0]);
    chk("is_sum", red_is_sum_o, is_sum);
    chk("busy_ready", req_ready_o, 0);
    tick();
    chk("beat1_start", red_start_o, 1);
    chk("beat1_data", red_operand_o, vec[511:256]);
    tick();
    chk("wait_start", red_start_o, 0);
    chk("wait_operand", red_operand_o, 0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic accept_rsp();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("rsp_gone", rsp_valid_o, 0);
    chk("ready_back", req_ready_o, 1);
  endtask

  logic [511:0] v;
  int n;
  int acc[3];
  int na;
  int cyc;

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_is_sum_i = 1'b0; req_data_i = '0;
    red_dout_i = '0; rsp_ready_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_start", red_start_o, 0);
    chk("rst_operand", red_operand_o, 0);
    chk("rst_is_sum", red_is_sum_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_spurious", spurious_o, 0);
    chk("rst_op_cnt", op_cnt_o, 0);
    tick();

    // FSUM of 32 x 1.0
    model_en = 1'b1; model_dly = 6; red_dout_i = {16{16'h4200}};
    issue(1'b1, {32{16'h3F80}});
    wait_rsp(n);
    chk("fsum_latency", n, 6);
    chk("fsum_data", rsp_data_o, 16'h4200);
    chk("fsum_err", rsp_err_o, 0);
    chk("fsum_is_sum", red_is_sum_o, 1);
    accept_rsp();
    chk("fsum_op_cnt", op_cnt_o, 1);

    // FMAX with element 17 largest, response held off for 4 cycles
    v = {32{16'h3F80}};
    v[17*16 +: 16] = 16'h4120;
    red_dout_i = {16{16'h4120}};
    issue(1'b0, v);
    wait_rsp(n);
    chk("fmax_latency", n, 6);
    chk("fmax_is_sum", red_is_sum_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fmax_hold_valid", rsp_valid_o, 1);
      chk("fmax_hold_data", rsp_data_o, 16'h4120);
      chk("fmax_hold_ready", req_ready_o, 0);
    end
    accept_rsp();
    chk("fmax_op_cnt", op_cnt_o, 2);

    // no done: timeout
    model_en = 1'b0;
    issue(1'b1, {32{16'h3F80}});
    wait_rsp(n);
    chk("to_latency", n, 64);
    chk("to_err", rsp_err_o, 1);
    chk("to_data", rsp_data_o, 0);
    accept_rsp();
    chk("to_op_cnt", op_cnt_o, 3);

    // done on the timeout cycle wins
    model_en = 1'b1; model_dly = 64; red_dout_i = {16{16'h1234}};
    issue(1'b1, {32{16'h3F80}});
    wait_rsp(n);
    chk("edge_latency", n, 64);
    chk("edge_err", rsp_err_o, 0);
    chk("edge_data", rsp_data_o, 16'h1234);
    chk("edge_no_spur", spurious_o, 0);
    accept_rsp();
    chk("edge_op_cnt", op_cnt_o, 4);

    // spurious done in IDLE, stray rsp_ready in IDLE
    spur_pulse = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (3) tick();
    rsp_ready_i = 1'b0;
    chk("spur_set", spurious_o, 1);
    chk("idle_rsp_ready_noop", op_cnt_o, 4);
    model_dly = 6; red_dout_i = {16{16'h5555}};
    issue(1'b1, {32{16'h3F80}});
    wait_rsp(n);
    chk("post_spur_data", rsp_data_o, 16'h5555);
    red_dout_i = {16{16'hDEAD}};
    spur_pulse = 1'b1;
    repeat (2) tick();
    chk("resp_done_ignored", rsp_data_o, 16'h5555);
    chk("spur_sticky", spurious_o, 1);
    accept_rsp();
    chk("post_spur_op_cnt", op_cnt_o, 5);

    // reset during WAIT
    model_en = 1'b0;
    issue(1'b1, {32{16'h3F80}});
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", req_ready_o, 1);
    chk("mid_rst_spur", spurious_o, 0);
    chk("mid_rst_op_cnt", op_cnt_o, 0);
    chk("mid_rst_is_sum", red_is_sum_o, 0);
    chk("mid_rst_valid", rsp_valid_o, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", req_ready_o, 1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (rsp_valid_o) n++;
      tick();
    end
    chk("post_rst_no_rsp", n, 0);

    // counter wrap plus back-to-back spacing
    force dut.op_cnt_q = 16'hFFFF;
    #1;
    release dut.op_cnt_q;
    chk("preset_op_cnt", op_cnt_o, 16'hFFFF);
    tick();
    model_en = 1'b1; model_dly = 1; red_dout_i = {16{16'h0101}};
    req_is_sum_i = 1'b1; req_data_i = {32{16'h3F80}};
    rsp_ready_i = 1'b1; req_valid_i = 1'b1;
    na = 0; cyc = 0;
    while (na < 3 && cyc < 40) begin
      if (req_ready_o) begin
        acc[na] = cyc;
        if (na == 1) chk("wrap_op_cnt", op_cnt_o, 0);
        na++;
      end
      tick();
      cyc++;
    end
    req_valid_i = 1'b0;
    chk("b2b_accepts", na, 3);
    chk("b2b_gap0", acc[1] - acc[0], 5);
    chk("b2b_gap1", acc[2] - acc[1], 5);
    repeat (8) tick();
    chk("b2b_op_cnt", op_cnt_o, 2);
    rsp_ready_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
